ni_tx: RTL and testbench

Network-interface transmitter for the 2x4 mesh NoC. It takes a message descriptor (destination, length) and payload words from the local core. It emits head, body and tail flits into the router's local input port, which performs XY route computation on the head flit's destination field. Flow control toward the router is credit-based: one credit per free slot in the router's local input buffer.

---
 rtl/ni_tx_pkg.sv | 22 ++
 rtl/ni_credit_cnt.sv | 36 +++
 rtl/ni_tx.sv | 129 ++++++++++++
 tb/tb_ni_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_tx_pkg.sv
// Shared NoC definitions: flit type encodings, head-flit field offsets and
// the transmitter FSM state type. The router decodes the same fields.
package ni_tx_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_HT   = 2'b11
  } flit_type_e;

  localparam int HDR_DST_LSB = 0;
  localparam int HDR_SRC_LSB = 3;
  localparam int HDR_LEN_LSB = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HEAD = 2'b01,
    S_BODY = 2'b10
  } tx_state_e;

endpackage

// File: rtl/ni_credit_cnt.sv
// Credit counter for the router's local input buffer. Starts full, drops by
// one per issued flit, rises by one per returned credit. A return while
// already full is a protocol error: the count saturates and err latches.
module ni_credit_cnt #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o,
  output logic err_o
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Count update; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(CREDITS);
      err_q <= 1'b0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == CW'(CREDITS)) err_q <= 1'b1;
      else                       cnt_q <= cnt_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign avail_o = (cnt_q != '0);
  assign err_o   = err_q;

endmodule

// File: rtl/ni_tx.sv
// Network-interface transmitter: turns a (dst, len) descriptor plus len
// payload words into head/body/tail flits for the router's local port,
// gated by credits. Flit outputs are registered; issue at edge N shows
// up in cycle N+1.
module ni_tx
  import ni_tx_pkg::*;
#(
  parameter logic [2:0] NODE_ADD = 3'b000,
  parameter int         DATA_W   = 32,
  parameter int         LEN_W    = 3,
  parameter int         CREDITS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [2:0]        msg_dst_i,
  input  logic [LEN_W-1:0]  msg_len_i,
  input  logic              pl_valid_i,
  input  logic [DATA_W-1:0] pl_data_i,
  output logic              pl_ready_o,
  output logic              flit_valid_o,
  output logic [1:0]        flit_type_o,
  output logic [DATA_W-1:0] flit_data_o,
  input  logic              credit_in_i,
  output logic              credit_err_o
);

  tx_state_e         state_q;
  logic [2:0]        dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic              msg_ready_q;
  logic              flit_valid_q;
  flit_type_e        flit_type_q;
  logic [DATA_W-1:0] flit_data_q;

  logic              avail;
  logic              issue_head;
  logic              issue_body;
  logic              issue;
  logic [DATA_W-1:0] head_data;

  assign issue_head = (state_q == S_HEAD) && avail;
  assign issue_body = (state_q == S_BODY) && avail && pl_valid_i;
  assign issue      = issue_head || issue_body;

  ni_credit_cnt #(.CREDITS(CREDITS)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (credit_in_i),
    .dec_i   (issue),
    .avail_o (avail),
    .err_o   (credit_err_o)
  );

  // Head flit layout: len, source node and destination, upper bits zero.
  always_comb begin
    head_data                         = '0;
    head_data[HDR_DST_LSB +: 3]       = dst_q;
    head_data[HDR_SRC_LSB +: 3]       = NODE_ADD;
    head_data[HDR_LEN_LSB +: LEN_W]   = len_q;
  end

  // Packet FSM plus the registered flit and msg_ready outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dst_q        <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      msg_ready_q  <= 1'b1;
      flit_valid_q <= 1'b0;
      flit_type_q  <= FLIT_BODY;
      flit_data_q  <= '0;
    end else begin
      flit_valid_q <= issue;
      case (state_q)
        S_IDLE: begin
          if (msg_valid_i && msg_ready_q) begin
            dst_q       <= msg_dst_i;
            len_q       <= msg_len_i;
            rem_q       <= msg_len_i;
            msg_ready_q <= 1'b0;
            state_q     <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (issue_head) begin
            flit_data_q <= head_data;
            if (len_q == '0) begin
              flit_type_q <= FLIT_HT;
              msg_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              flit_type_q <= FLIT_HEAD;
              state_q     <= S_BODY;
            end
          end
        end
        S_BODY: begin
          if (issue_body) begin
            flit_data_q <= pl_data_i;
            rem_q       <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              flit_type_q <= FLIT_TAIL;
              msg_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              flit_type_q <= FLIT_BODY;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          msg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Payload is taken only while a body slot can actually be issued.
  assign pl_ready_o   = (state_q == S_BODY) && avail;
  assign msg_ready_o  = msg_ready_q;
  assign flit_valid_o = flit_valid_q;
  assign flit_type_o  = flit_type_q;
  assign flit_data_o  = flit_data_q;

endmodule

// File: tb/tb_ni_tx.sv
// Directed bench for ni_tx: expected flits are queued when a packet is
// offered and compared in order as flits appear on the output.
module tb_ni_tx;
  import ni_tx_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        msg_valid;
  logic        msg_ready;
  logic [2:0]  msg_dst;
  logic [2:0]  msg_len;
  logic        pl_valid;
  logic [31:0] pl_data;
  logic        pl_ready;
  logic        flit_valid;
  logic [1:0]  flit_type;
  logic [31:0] flit_data;
  logic        credit_in;
  logic        credit_err;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] d;
  } flit_t;

  flit_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    stalls = 0;

  ni_tx #(.NODE_ADD(3'b000), .DATA_W(32), .LEN_W(3), .CREDITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_valid_i  (msg_valid),
    .msg_ready_o  (msg_ready),
    .msg_dst_i    (msg_dst),
    .msg_len_i    (msg_len),
    .pl_valid_i   (pl_valid),
    .pl_data_i    (pl_data),
    .pl_ready_o   (pl_ready),
    .flit_valid_o (flit_valid),
    .flit_type_o  (flit_type),
    .flit_data_o  (flit_data),
    .credit_in_i  (credit_in),
    .credit_err_o (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] d);
    flit_t f;
    f.t = t;
    f.d = d;
    sbq.push_back(f);
  endtask

  task automatic credit_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      credit_in = 1'b1;
      tick();
    end
    credit_in = 1'b0;
  endtask

  // Offer one payload word and wait (bounded) until it is consumed.
  task automatic send_word(input logic [31:0] d);
    bit done;
    done     = 1'b0;
    pl_valid = 1'b1;
    pl_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (pl_ready) done = 1'b1;
      else          stalls++;
      tick();
    end
    chk("pl_consumed", 64'(done), 64'd1);
  endtask

  // Scoreboard: every visible flit must match the oldest expected one.
  always @(negedge clk) begin
    flit_t e;
    if (rst_n && flit_valid) begin
      if (sbq.size() > 0) e = sbq.pop_front();
      else begin
        e.t = 2'bxx;
        e.d = 'x;
      end
      chk("flit_type", 64'(flit_type), 64'(e.t));
      chk("flit_data", 64'(flit_data), 64'(e.d));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; msg_valid = 1'b0; msg_dst = '0; msg_len = '0;
    pl_valid = 1'b0; pl_data = '0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_msg_ready",  64'(msg_ready), 64'd1);
    chk("rst_pl_ready",   64'(pl_ready), 64'd0);
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_flit_type",  64'(flit_type), 64'd0);
    chk("rst_flit_data",  64'(flit_data), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    chk("rst_credits",    64'(dut.u_cnt.cnt_q), 64'd4);

    // len=2 to node 5: head/body/tail in cycles 2,3,4
    push(FLIT_HEAD, 32'h0000_0085);
    push(FLIT_BODY, 32'hA5A5_0001);
    push(FLIT_TAIL, 32'hA5A5_0002);
    msg_valid = 1'b1; msg_dst = 3'b101; msg_len = 3'd2;
    pl_valid = 1'b1; pl_data = 32'hA5A5_0001;
    tick();                                   // handshake edge 0
    msg_valid = 1'b0;
    chk("p1_c1_msg_ready",  64'(msg_ready), 64'd0);
    chk("p1_c1_flit_valid", 64'(flit_valid), 64'd0);
    chk("p1_c1_pl_ready",   64'(pl_ready), 64'd0);
    tick();
    chk("p1_c2_flit_valid", 64'(flit_valid), 64'd1);
    chk("p1_c2_pl_ready",   64'(pl_ready), 64'd1);
    tick();
    pl_data = 32'hA5A5_0002;
    chk("p1_c3_flit_valid", 64'(flit_valid), 64'd1);
    tick();
    pl_valid = 1'b0;
    chk("p1_c4_flit_valid", 64'(flit_valid), 64'd1);
    chk("p1_c4_msg_ready",  64'(msg_ready), 64'd1);
    chk("p1_credits",       64'(dut.u_cnt.cnt_q), 64'd1);
    tick();
    chk("p1_c5_flit_valid", 64'(flit_valid), 64'd0);

    // Header-only packet
    push(FLIT_HT, 32'h0000_0003);
    msg_valid = 1'b1; msg_dst = 3'b011; msg_len = 3'd0;
    tick();
    msg_valid = 1'b0;
    chk("ht_c1_msg_ready", 64'(msg_ready), 64'd0);
    tick();
    chk("ht_c2_flit_valid", 64'(flit_valid), 64'd1);
    chk("ht_c2_msg_ready",  64'(msg_ready), 64'd1);
    tick();
    chk("ht_c3_flit_valid", 64'(flit_valid), 64'd0);
    chk("ht_credits",       64'(dut.u_cnt.cnt_q), 64'd0);
    credit_pulses(4);
    chk("refill_credits", 64'(dut.u_cnt.cnt_q), 64'd4);
    chk("refill_err",     64'(credit_err), 64'd0);

    // len=6 with 4 credits: stall after 4 flits, one pulse frees one body
    push(FLIT_HEAD, 32'h0000_0182);
    for (int i = 1; i <= 6; i++)
      push((i == 6) ? FLIT_TAIL : FLIT_BODY, 32'h0B00_0000 | 32'(i));
    msg_valid = 1'b1; msg_dst = 3'b010; msg_len = 3'd6;
    tick();
    msg_valid = 1'b0;
    send_word(32'h0B00_0001);
    send_word(32'h0B00_0002);
    send_word(32'h0B00_0003);
    pl_valid = 1'b1; pl_data = 32'h0B00_0004;
    chk("stall_pl_ready", 64'(pl_ready), 64'd0);
    tick();
    chk("stall_flit_valid0", 64'(flit_valid), 64'd0);
    chk("stall_credits",     64'(dut.u_cnt.cnt_q), 64'd0);
    tick();
    chk("stall_flit_valid1", 64'(flit_valid), 64'd0);
    chk("stall_pl_ready1",   64'(pl_ready), 64'd0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("pulse_pl_ready",   64'(pl_ready), 64'd1);
    chk("pulse_flit_valid", 64'(flit_valid), 64'd0);
    tick();
    pl_data = 32'h0B00_0005;
    chk("one_more_flit",    64'(flit_valid), 64'd1);
    chk("one_more_pl_rdy",  64'(pl_ready), 64'd0);
    tick();
    chk("only_one_flit",    64'(flit_valid), 64'd0);
    pl_valid = 1'b0;
    credit_pulses(2);
    send_word(32'h0B00_0005);
    send_word(32'h0B00_0006);
    pl_valid = 1'b0;
    tick();
    tick();
    chk("p3_msg_ready", 64'(msg_ready), 64'd1);
    chk("p3_credits",   64'(dut.u_cnt.cnt_q), 64'd0);
    credit_pulses(4);

    // Credit returned alongside every issue: count steady, no stall
    push(FLIT_HEAD, 32'h0000_01C7);
    for (int i = 1; i <= 7; i++)
      push((i == 7) ? FLIT_TAIL : FLIT_BODY, 32'hC000_0000 | 32'(i));
    msg_valid = 1'b1; msg_dst = 3'b111; msg_len = 3'd7;
    tick();
    msg_valid = 1'b0;
    credit_in = 1'b1;
    tick();                                   // head issued with credit
    stalls = 0;
    for (int i = 1; i <= 7; i++) begin
      send_word(32'hC000_0000 | 32'(i));
      if (i == 3) chk("steady_mid_credits", 64'(dut.u_cnt.cnt_q), 64'd4);
    end
    credit_in = 1'b0;
    pl_valid  = 1'b0;
    chk("steady_stalls",  64'(stalls), 64'd0);
    chk("steady_credits", 64'(dut.u_cnt.cnt_q), 64'd4);
    chk("steady_err",     64'(credit_err), 64'd0);
    tick();
    tick();

    // Credit return while full: error sticks, count saturates
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("ovf_err",     64'(credit_err), 64'd1);
    chk("ovf_credits", 64'(dut.u_cnt.cnt_q), 64'd4);
    repeat (3) tick();
    chk("ovf_err_sticky", 64'(credit_err), 64'd1);

    // Reset in the middle of a len=5 packet
    push(FLIT_HEAD, 32'h0000_0146);
    for (int i = 1; i <= 5; i++)
      push((i == 5) ? FLIT_TAIL : FLIT_BODY, 32'hD000_0000 | 32'(i));
    msg_valid = 1'b1; msg_dst = 3'b110; msg_len = 3'd5;
    tick();
    msg_valid = 1'b0;
    send_word(32'hD000_0001);
    send_word(32'hD000_0002);
    pl_data = 32'hD000_0003;
    #6 rst_n = 1'b0;
    #1;
    chk("mr_flit_valid", 64'(flit_valid), 64'd0);
    chk("mr_msg_ready",  64'(msg_ready), 64'd1);
    chk("mr_pl_ready",   64'(pl_ready), 64'd0);
    chk("mr_credit_err", 64'(credit_err), 64'd0);
    chk("mr_credits",    64'(dut.u_cnt.cnt_q), 64'd4);
    chk("mr_pending",    64'(sbq.size()), 64'd3);
    sbq.delete();
    pl_valid = 1'b0;
    #4 rst_n = 1'b1;
    tick();

    // Fresh packet after reset must start with a head flit
    push(FLIT_HEAD, 32'h0000_0044);
    push(FLIT_TAIL, 32'hE000_0001);
    msg_valid = 1'b1; msg_dst = 3'b100; msg_len = 3'd1;
    tick();
    msg_valid = 1'b0;
    send_word(32'hE000_0001);
    pl_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_drained",   64'(sbq.size()), 64'd0);
    chk("post_rst_msg_ready", 64'(msg_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
